// File: rtl/fpu_pkg.sv
// Shared types and constants for the FP add/sub arbitration path.
package fpu_pkg;

    localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;
    localparam int          FP_SIGN_BIT = 31;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
    } fp_req_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    logic [NREQ-1:0] rot;
    logic [IDW-1:0]  off;
    logic [IDW:0]    sum;

    always_comb begin
        // rot[k] = req[(ptr + k) mod NREQ]; lowest k wins
        rot = NREQ'({req, req} >> ptr);
        off = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (rot[k]) off = IDW'(k);
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
        idx = sum[IDW-1:0];
        any = |req;
        gnt = any ? (NREQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/fp_addsub_arbiter.sv
// Round-robin front end sharing one fp_add_sub core among NREQ requesters,
// one operation in flight, with a watchdog that aborts a hung core.
module fp_addsub_arbiter
    import fpu_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TMO_CYC = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_op,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_data,
    output logic                 rsp_err,
    output logic                 core_start,
    output logic [31:0]          core_num1,
    output logic [31:0]          core_num2,
    input  logic                 core_done,
    input  logic [31:0]          core_out
);

    localparam int WDW = $clog2(TMO_CYC + 1);

    arb_state_e      state, state_nxt;
    logic [IDW-1:0]  rr_ptr, lat_id, pick_idx;
    logic [NREQ-1:0] pick_gnt;
    logic            pick_any;
    logic [WDW-1:0]  wdog, wdog_inc;
    logic            wd_hit;
    fp_req_t         sel;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        sel = '0;
        for (int i = 0; i < NREQ; i++)
            if (pick_gnt[i]) sel = '{a: req_a[32*i +: 32], b: req_b[32*i +: 32], op: req_op[i]};
    end

    assign req_ready  = (state == IDLE && !rst) ? pick_gnt : '0;
    assign core_start = (state == ISSUE) && !rst;
    assign rsp_valid  = (state == RESP) && !rst;

    // wdog counts WAIT cycles including the current one, so the limit is hit
    // on the TMO_CYC-th cycle of WAIT and RESP follows immediately.
    assign wdog_inc = (wdog == WDW'(TMO_CYC)) ? wdog : wdog + 1'b1;
    assign wd_hit   = (wdog_inc == WDW'(TMO_CYC));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_any) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (core_done || wd_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            lat_id    <= '0;
            wdog      <= '0;
            core_num1 <= '0;
            core_num2 <= '0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (pick_any) begin
                    // operands are presented to the core already during ISSUE
                    lat_id    <= pick_idx;
                    core_num1 <= sel.a;
                    core_num2 <= sel.b ^ (32'(sel.op) << FP_SIGN_BIT);
                end
                ISSUE: wdog <= '0;
                WAIT: begin
                    wdog <= wdog_inc;
                    if (core_done) begin
                        rsp_data <= core_out;
                        rsp_err  <= 1'b0;
                        rsp_id   <= lat_id;
                    end else if (wd_hit) begin
                        rsp_data <= FP_QNAN;
                        rsp_err  <= 1'b1;
                        rsp_id   <= lat_id;
                    end
                end
                RESP: rr_ptr <= (lat_id == IDW'(NREQ - 1)) ? '0 : lat_id + 1'b1;
                default: ;
            endcase
        end
    end

endmodule
